// File: rtl/y_signature_compactor.sv
// Compacts the DUT result vector y into a MISR signature and a change count
// over a programmed window of CYCLES samples, then holds the results until restarted.
module y_signature_compactor #(
  parameter int          DATA_W = 81,
  parameter int          SIG_W  = 32,
  parameter logic [63:0] POLY   = 64'h04C11DB7,
  parameter logic [63:0] SEED   = 64'h00000001,
  parameter int          CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] y_in,
  output logic              busy,
  output logic              done,
  output logic [SIG_W-1:0]  signature,
  output logic [15:0]       sample_cnt,
  output logic [15:0]       change_cnt,
  output logic [1:0]        dbg_state
);

  localparam int          NSLICE = (DATA_W + SIG_W - 1) / SIG_W;
  localparam int          PAD_W  = NSLICE * SIG_W;
  localparam logic [15:0] LAST   = 16'(CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [SIG_W-1:0]   r_sig;
  logic [15:0]        r_sample_cnt;
  logic [15:0]        r_change_cnt;
  logic [DATA_W-1:0]  r_prev_y;
  logic [PAD_W-1:0]   w_pad;
  logic [SIG_W-1:0]   w_fold;
  logic [SIG_W-1:0]   w_sig_next;
  logic               w_start_win;
  logic               w_changed;

  // Start is only honoured outside RUN, so a pulse mid-window is ignored.
  assign w_start_win = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (r_sample_cnt == LAST) w_next = S_DONE;
      S_DONE:  if (start) w_next = S_RUN;
      default: w_next = S_IDLE;
    endcase
  end

  // The top slice of y is zero-padded before the slices are XOR-folded.
  always_comb begin
    w_pad              = '0;
    w_pad[DATA_W-1:0]  = y_in;
    w_fold             = '0;
    for (int k = 0; k < NSLICE; k++) begin
      w_fold = w_fold ^ w_pad[k*SIG_W +: SIG_W];
    end
  end

  assign w_sig_next = {r_sig[SIG_W-2:0], 1'b0}
                    ^ (r_sig[SIG_W-1] ? POLY[SIG_W-1:0] : '0)
                    ^ w_fold;

  assign w_changed = (r_sample_cnt != 16'd0) && (y_in != r_prev_y);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig        <= '0;
      r_sample_cnt <= '0;
      r_change_cnt <= '0;
      r_prev_y     <= '0;
    end else if (w_start_win) begin
      r_sig        <= SEED[SIG_W-1:0];
      r_sample_cnt <= '0;
      r_change_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_sig        <= w_sig_next;
      r_sample_cnt <= r_sample_cnt + 16'd1;
      r_prev_y     <= y_in;
      if (w_changed && (r_change_cnt != 16'hFFFF)) begin
        r_change_cnt <= r_change_cnt + 16'd1;
      end
    end
  end

  assign busy       = (r_state == S_RUN);
  assign done       = (r_state == S_DONE);
  assign signature  = r_sig;
  assign sample_cnt = r_sample_cnt;
  assign change_cnt = r_change_cnt;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_y_signature_compactor.sv
// Directed bench for y_signature_compactor: four instances with different window
// lengths and seeds share clock, reset and y_in; results are checked from a queue.
module tb_y_signature_compactor;

  logic        clk;
  logic        rst_n;
  logic [80:0] y_in;
  logic        start_v [4];
  logic        busy_v  [4];
  logic        done_v  [4];
  logic [31:0] sig_v   [4];
  logic [15:0] sc_v    [4];
  logic [15:0] cc_v    [4];
  logic [1:0]  st_v    [4];

  int          n_cmp;
  int          n_bad;
  logic [63:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instances ----------------
  y_signature_compactor #(.CYCLES(4), .SEED(64'h1)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .y_in(y_in),
    .busy(busy_v[0]), .done(done_v[0]), .signature(sig_v[0]),
    .sample_cnt(sc_v[0]), .change_cnt(cc_v[0]), .dbg_state(st_v[0]));

  y_signature_compactor #(.CYCLES(1), .SEED(64'h0)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .y_in(y_in),
    .busy(busy_v[1]), .done(done_v[1]), .signature(sig_v[1]),
    .sample_cnt(sc_v[1]), .change_cnt(cc_v[1]), .dbg_state(st_v[1]));

  y_signature_compactor #(.CYCLES(1), .SEED(64'h80000000)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .y_in(y_in),
    .busy(busy_v[2]), .done(done_v[2]), .signature(sig_v[2]),
    .sample_cnt(sc_v[2]), .change_cnt(cc_v[2]), .dbg_state(st_v[2]));

  y_signature_compactor #(.CYCLES(6), .SEED(64'h1)) u_d (
    .clk(clk), .rst_n(rst_n), .start(start_v[3]), .y_in(y_in),
    .busy(busy_v[3]), .done(done_v[3]), .signature(sig_v[3]),
    .sample_cnt(sc_v[3]), .change_cnt(cc_v[3]), .dbg_state(st_v[3]));

  // ---------------- model ----------------
  function automatic logic [31:0] misr(input logic [31:0] s, input logic [80:0] y);
    logic [95:0] p;
    logic [31:0] f;
    p       = '0;
    p[80:0] = y;
    f       = p[31:0] ^ p[63:32] ^ p[95:64];
    return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ f;
  endfunction

  // ---------------- driver / check tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input int idx);
    start_v[idx] = 1'b1;
    tick();
    start_v[idx] = 1'b0;
  endtask

  task automatic wait_done(input int idx, input int budget);
    int n;
    n = 0;
    while (!done_v[idx] && n < budget) begin
      tick();
      n++;
    end
    chk("done_within_budget", {63'd0, done_v[idx]}, 64'd1);
  endtask

  task automatic pop_cmp(input int idx, input string tag);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_sig"},     {32'd0, sig_v[idx]}, {32'd0, e[63:32]});
      chk({tag, "_samples"}, {48'd0, sc_v[idx]},  {48'd0, e[31:16]});
      chk({tag, "_changes"}, {48'd0, cc_v[idx]},  {48'd0, e[15:0]});
    end
  endtask

  task automatic chk_zero(input int idx, input string tag);
    chk({tag, "_busy"},  {63'd0, busy_v[idx]}, 64'd0);
    chk({tag, "_done"},  {63'd0, done_v[idx]}, 64'd0);
    chk({tag, "_sig"},   {32'd0, sig_v[idx]},  64'd0);
    chk({tag, "_scnt"},  {48'd0, sc_v[idx]},   64'd0);
    chk({tag, "_ccnt"},  {48'd0, cc_v[idx]},   64'd0);
    chk({tag, "_state"}, {62'd0, st_v[idx]},   64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [80:0] seq [6];
    logic [80:0] base;
    logic [31:0] s;
    int          ch;

    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    y_in  = '0;
    for (int i = 0; i < 4; i++) start_v[i] = 1'b0;

    // reset idle
    repeat (3) tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk_zero(0, "idle_a");
    end
    for (int i = 1; i < 4; i++) chk_zero(i, "idle_other");

    // zero stream with exact done timing
    y_in = '0;
    exp_q.push_back({32'h00000010, 16'd4, 16'd0});
    pulse_start(0);
    chk("zs_busy_after_e0", {63'd0, busy_v[0]}, 64'd1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("zs_done_sched", {63'd0, done_v[0]}, {63'd0, (i == 4)});
      chk("zs_busy_sched", {63'd0, busy_v[0]}, {63'd0, (i != 4)});
    end
    pop_cmp(0, "zero_stream");
    repeat (3) tick();
    chk("zs_hold_sig", {32'd0, sig_v[0]}, 64'h10);

    // restart from DONE clears counts and loads seed
    pulse_start(0);
    chk("rs_busy", {63'd0, busy_v[0]}, 64'd1);
    chk("rs_done", {63'd0, done_v[0]}, 64'd0);
    chk("rs_scnt", {48'd0, sc_v[0]},   64'd0);
    chk("rs_ccnt", {48'd0, cc_v[0]},   64'd0);
    chk("rs_seed", {32'd0, sig_v[0]},  64'd1);
    exp_q.push_back({32'h00000010, 16'd4, 16'd0});
    wait_done(0, 20);
    pop_cmp(0, "restart_window");

    // fold cancellation then single injection
    y_in = '0;
    y_in[0]  = 1'b1;
    y_in[32] = 1'b1;
    exp_q.push_back({32'h0, 16'd1, 16'd0});
    pulse_start(1);
    wait_done(1, 10);
    pop_cmp(1, "fold_cancel");
    y_in = '0;
    y_in[0] = 1'b1;
    exp_q.push_back({32'h1, 16'd1, 16'd0});
    pulse_start(1);
    wait_done(1, 10);
    pop_cmp(1, "fold_single");

    // feedback tap
    y_in = '0;
    exp_q.push_back({32'h04C11DB7, 16'd1, 16'd0});
    pulse_start(2);
    wait_done(2, 10);
    pop_cmp(2, "feedback");

    // change counting A,A,B,B,A,C with a start pulse mid-window
    base   = {$urandom(), $urandom(), $urandom()};
    seq[0] = base;
    seq[1] = base;
    seq[2] = base ^ 81'h1;
    seq[3] = base ^ 81'h1;
    seq[4] = base;
    seq[5] = base ^ (81'h1 << 70);
    s = 32'h1;
    for (int i = 0; i < 6; i++) s = misr(s, seq[i]);
    exp_q.push_back({s, 16'd6, 16'd3});
    pulse_start(3);
    for (int i = 0; i < 6; i++) begin
      y_in = seq[i];
      if (i == 2) start_v[3] = 1'b1;
      tick();
      start_v[3] = 1'b0;
      chk("chg_done_sched", {63'd0, done_v[3]}, {63'd0, (i == 5)});
    end
    pop_cmp(3, "change_count");

    // random window
    for (int i = 0; i < 6; i++) begin
      seq[i] = ($urandom_range(0, 1) == 1) ? {$urandom(), $urandom(), $urandom()} : base;
    end
    s  = 32'h1;
    ch = 0;
    for (int i = 0; i < 6; i++) begin
      s = misr(s, seq[i]);
      if (i > 0 && seq[i] != seq[i-1]) ch++;
    end
    exp_q.push_back({s, 16'd6, 16'(ch)});
    pulse_start(3);
    for (int i = 0; i < 6; i++) begin
      y_in = seq[i];
      tick();
    end
    chk("rnd_done", {63'd0, done_v[3]}, 64'd1);
    pop_cmp(3, "random_window");

    // asynchronous reset mid-window after two samples
    y_in = {$urandom(), $urandom(), $urandom()};
    pulse_start(3);
    tick();
    y_in = ~y_in;
    tick();
    chk("ar_two_samples", {48'd0, sc_v[3]}, 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero(3, "async_rst_d");
    chk_zero(0, "async_rst_a");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_zero(3, "post_rst_d");

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
